calc_sequencer: RTL
===================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width; SHALL match the ALU operand width.
REQ-002 Parameter OP_W, default 3, ALU operation-select width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 key_valid  input  1  one-cycle strobe qualifying key_code.
REQ-006 key_code  input  5  0-9 digit, 10 add, 11 sub, 12 and, 13 or, 14 equals, 15 clear; 16-31 ignored.
REQ-007 opt  output  OP_W  to ALU: 0 pass, 1 add, 2 sub, 3 and, 4 or.
REQ-008 numa  output  DATA_W  to ALU, operand A register.
REQ-009 numb  output  DATA_W  to ALU, operand B register.
REQ-010 ci  output  DATA_W  to ALU, SHALL be constant 0.
REQ-011 s  input  DATA_W  ALU result, combinational from opt/numa/numb.
REQ-012 zero  input  1  ALU zero flag.
REQ-013 co  input  1  ALU carry/borrow flag.
REQ-014 disp  output  DATA_W  value shown to user.
REQ-015 res_valid  output  1  one-cycle pulse when a result is captured.
REQ-016 carry_flag  output  1  co captured with the last result; sticky until next result or clear.
REQ-017 zero_flag  output  1  zero captured with the last result.
REQ-018 busy  output  1  high in EXEC; keys arriving in EXEC SHALL be dropped.

Function
REQ-019 FSM states: ENTER_A, OP_WAIT, ENTER_B, EXEC, SHOW.
REQ-020 ENTER_A: digit d -> numa = numa*10 + d; op key -> latch opt, go OP_WAIT; equals ignored.
REQ-021 OP_WAIT: digit -> numb = d, go ENTER_B; op key -> replace latched opt; equals ignored.
REQ-022 ENTER_B: digit -> numb = numb*10 + d; equals -> EXEC with next_op = pass; op key -> EXEC with next_op = new op (chaining).
REQ-023 Digit accumulation: if numX*10 + d > 2^DATA_W-1, the digit SHALL be dropped and the register left unchanged.
REQ-024 EXEC lasts exactly one cycle; opt/numa/numb SHALL be stable throughout; at its closing edge s, co, zero are captured.
REQ-025 Capture: disp = s, carry_flag = co, zero_flag = zero, res_valid = 1 for one cycle, numa = s, numb = 0.
REQ-026 After EXEC: equals-terminated -> SHOW; chained -> opt = next_op, go OP_WAIT.
REQ-027 SHOW: digit -> numa = d, flags cleared, go ENTER_A; op key -> latch opt, go OP_WAIT (result reused as A).
REQ-028 Latency: equals accepted at edge N -> EXEC during cycle N+1 -> disp/res_valid updated at edge N+2.
REQ-029 disp tracks the register being entered: numa in ENTER_A, numb in ENTER_B, unchanged in OP_WAIT.
REQ-030 Clear (code 15) in any state except EXEC SHALL return all registers to reset values next edge; in EXEC it is dropped.
REQ-031 Arithmetic is modulo 2^DATA_W; wrap is reported only via carry_flag.

Reset
REQ-032 rst asserted SHALL immediately force ENTER_A, numa = numb = disp = 0, opt = 0, ci = 0, all flags and res_valid = 0, busy = 0.
REQ-033 rst asserted during EXEC SHALL abort without capture; no res_valid pulse follows deassertion.

Structure
REQ-034 Package calc_pkg SHALL hold key-code constants, ALU opt constants, and the FSM state enum.
REQ-035 One sub-module calc_digit_acc (value*10 + digit with overflow detect, shift-add, combinational) SHALL be used for both operands.

Verification
REQ-036 Keys 3,+,5,= -> opt 1 in EXEC, disp 8, res_valid pulse at edge N+2, carry_flag 0, zero_flag 0.
REQ-037 Keys 2,0,0,+,1,0,0,= -> disp 44, carry_flag 1.
REQ-038 Keys 6,-,1,2,= -> disp 250; then +,6,= -> disp 0, zero_flag 1.
REQ-039 Keys 2,5,6 -> numa stays 25; then 5 -> numa 255.
REQ-040 Chained 8,+,2,-,3,= -> first res_valid with disp 10, second with disp 7.
REQ-041 Assert rst in EXEC cycle -> outputs 0 same cycle, no res_valid; a key during busy is ignored.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the calculator sequencer: key codes, ALU operation
// selects and the sequencer state encoding.
package calc_pkg;

    localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;
    localparam logic [4:0] KEY_ADD       = 5'd10;
    localparam logic [4:0] KEY_SUB       = 5'd11;
    localparam logic [4:0] KEY_AND       = 5'd12;
    localparam logic [4:0] KEY_OR        = 5'd13;
    localparam logic [4:0] KEY_EQUALS    = 5'd14;
    localparam logic [4:0] KEY_CLEAR     = 5'd15;

    localparam logic [2:0] OPT_PASS = 3'd0;
    localparam logic [2:0] OPT_ADD  = 3'd1;
    localparam logic [2:0] OPT_SUB  = 3'd2;
    localparam logic [2:0] OPT_AND  = 3'd3;
    localparam logic [2:0] OPT_OR   = 3'd4;

    typedef enum logic [2:0] {
        ST_ENTER_A,
        ST_OP_WAIT,
        ST_ENTER_B,
        ST_EXEC,
        ST_SHOW
    } state_t;

    function automatic logic [2:0] key_to_opt(input logic [4:0] code);
        case (code)
            KEY_ADD: key_to_opt = OPT_ADD;
            KEY_SUB: key_to_opt = OPT_SUB;
            KEY_AND: key_to_opt = OPT_AND;
            KEY_OR:  key_to_opt = OPT_OR;
            default: key_to_opt = OPT_PASS;
        endcase
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Operand/result bus between the sequencer (master) and the external ALU (slave).
interface calc_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
);
    logic [OP_W-1:0]   opt;
    logic [DATA_W-1:0] numa;
    logic [DATA_W-1:0] numb;
    logic [DATA_W-1:0] ci;
    logic [DATA_W-1:0] s;
    logic              zero;
    logic              co;

    modport master (output opt, numa, numb, ci, input s, zero, co);
    modport slave  (input opt, numa, numb, ci, output s, zero, co);
endinterface

// File: rtl/calc_digit_acc.sv
// Decimal digit accumulator: value*10 + digit using shift-add, flags results
// that do not fit in DATA_W bits.
module calc_digit_acc #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] value,
    input  logic [3:0]        digit,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);
    logic [DATA_W+3:0] ext;
    logic [DATA_W+3:0] wide;

    // Four guard bits hold the worst case 10*(2^DATA_W-1)+9.
    assign ext      = {4'b0000, value};
    assign wide     = (ext << 3) + (ext << 1) + {{DATA_W{1'b0}}, digit};
    assign result   = wide[DATA_W-1:0];
    assign overflow = |wide[DATA_W+3:DATA_W];
endmodule

// File: rtl/calc_sequencer.sv
// Keypad-driven calculator sequencer: accumulates two decimal operands,
// drives an external ALU for one cycle and captures its result.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [4:0]        key_code,
    calc_sequencer_if.master  alu,
    output logic [DATA_W-1:0] disp,
    output logic              res_valid,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              busy
);
    state_t            state_reg, state_next;
    logic [DATA_W-1:0] numa_reg, numa_next;
    logic [DATA_W-1:0] numb_reg, numb_next;
    logic [DATA_W-1:0] disp_reg, disp_next;
    logic [OP_W-1:0]   opt_reg, opt_next;
    logic [OP_W-1:0]   next_op_reg, next_op_next;
    logic              res_valid_reg, res_valid_next;
    logic              carry_reg, carry_next;
    logic              zero_reg, zero_next;

    logic              is_digit, is_op, is_equals, is_clear;
    logic [DATA_W-1:0] digit_val;
    logic [OP_W-1:0]   key_opt;

    assign is_digit  = key_valid && (key_code <= KEY_DIGIT_MAX);
    assign is_op     = key_valid && (key_code >= KEY_ADD) && (key_code <= KEY_OR);
    assign is_equals = key_valid && (key_code == KEY_EQUALS);
    assign is_clear  = key_valid && (key_code == KEY_CLEAR);
    assign digit_val = DATA_W'(key_code[3:0]);
    assign key_opt   = OP_W'(key_to_opt(key_code));

    // Index 0 accumulates operand A, index 1 operand B.
    logic [DATA_W-1:0] acc_val [2];
    logic [DATA_W-1:0] acc_res [2];
    logic              acc_ovf [2];

    assign acc_val[0] = numa_reg;
    assign acc_val[1] = numb_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_acc
            calc_digit_acc #(.DATA_W(DATA_W)) u_acc (
                .value    (acc_val[gi]),
                .digit    (key_code[3:0]),
                .result   (acc_res[gi]),
                .overflow (acc_ovf[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_ENTER_A;
            numa_reg      <= '0;
            numb_reg      <= '0;
            disp_reg      <= '0;
            opt_reg       <= '0;
            next_op_reg   <= '0;
            res_valid_reg <= 1'b0;
            carry_reg     <= 1'b0;
            zero_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            numa_reg      <= numa_next;
            numb_reg      <= numb_next;
            disp_reg      <= disp_next;
            opt_reg       <= opt_next;
            next_op_reg   <= next_op_next;
            res_valid_reg <= res_valid_next;
            carry_reg     <= carry_next;
            zero_reg      <= zero_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        numa_next      = numa_reg;
        numb_next      = numb_reg;
        disp_next      = disp_reg;
        opt_next       = opt_reg;
        next_op_next   = next_op_reg;
        res_valid_next = 1'b0;
        carry_next     = carry_reg;
        zero_next      = zero_reg;

        if (is_clear && (state_reg != ST_EXEC)) begin
            state_next   = ST_ENTER_A;
            numa_next    = '0;
            numb_next    = '0;
            disp_next    = '0;
            opt_next     = '0;
            next_op_next = '0;
            carry_next   = 1'b0;
            zero_next    = 1'b0;
        end else begin
            case (state_reg)
                ST_ENTER_A: begin
                    if (is_digit) begin
                        if (!acc_ovf[0]) begin
                            numa_next = acc_res[0];
                            disp_next = acc_res[0];
                        end
                    end else if (is_op) begin
                        opt_next   = key_opt;
                        state_next = ST_OP_WAIT;
                    end
                end
                ST_OP_WAIT: begin
                    if (is_digit) begin
                        numb_next  = digit_val;
                        disp_next  = digit_val;
                        state_next = ST_ENTER_B;
                    end else if (is_op) begin
                        opt_next = key_opt;
                    end
                end
                ST_ENTER_B: begin
                    if (is_digit) begin
                        if (!acc_ovf[1]) begin
                            numb_next = acc_res[1];
                            disp_next = acc_res[1];
                        end
                    end else if (is_equals) begin
                        next_op_next = OP_W'(OPT_PASS);
                        state_next   = ST_EXEC;
                    end else if (is_op) begin
                        next_op_next = key_opt;
                        state_next   = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // All keys are dropped here; a pass next_op marks an equals-terminated run.
                    disp_next      = alu.s;
                    carry_next     = alu.co;
                    zero_next      = alu.zero;
                    res_valid_next = 1'b1;
                    numa_next      = alu.s;
                    numb_next      = '0;
                    if (next_op_reg == OP_W'(OPT_PASS)) begin
                        state_next = ST_SHOW;
                    end else begin
                        opt_next   = next_op_reg;
                        state_next = ST_OP_WAIT;
                    end
                end
                ST_SHOW: begin
                    if (is_digit) begin
                        numa_next  = digit_val;
                        disp_next  = digit_val;
                        carry_next = 1'b0;
                        zero_next  = 1'b0;
                        state_next = ST_ENTER_A;
                    end else if (is_op) begin
                        opt_next   = key_opt;
                        state_next = ST_OP_WAIT;
                    end
                end
                default: state_next = ST_ENTER_A;
            endcase
        end
    end

    assign alu.opt    = opt_reg;
    assign alu.numa   = numa_reg;
    assign alu.numb   = numb_reg;
    assign alu.ci     = '0;
    assign disp       = disp_reg;
    assign res_valid  = res_valid_reg;
    assign carry_flag = carry_reg;
    assign zero_flag  = zero_reg;
    assign busy       = (state_reg == ST_EXEC);
endmodule
